// File: rtl/vz_pkg.sv
// Shared VZ image format definitions for the download loader and the upload engine,
// so both ends of the HPS ioctl path agree on the header layout.
package vz_pkg;

  localparam int VZ_HDR_LEN   = 24;
  localparam int VZ_OFF_NAME  = 4;
  localparam int VZ_OFF_TYPE  = 21;
  localparam int VZ_OFF_START = 22;

  localparam logic [7:0] VZ_TYPE_BASIC = 8'hF0;
  localparam logic [7:0] VZ_TYPE_BIN   = 8'hF1;

  // Ascending packed ranges so element [0] is the first byte on the wire.
  localparam logic [0:3][7:0]  VZ_MAGIC        = {8'h56, 8'h5A, 8'h46, 8'h30};
  localparam logic [0:16][7:0] VZ_NAME_DEFAULT = {"LASER310", 72'h0};

  typedef enum logic [2:0] {
    IDLE,
    ARM,
    WAIT_RD,
    HDR,
    MEM,
    DONE_BYTE
  } vz_up_state_t;

  // Inclusive span length; an inverted span yields an empty (header-only) image.
  function automatic logic [16:0] vz_span_len(input logic [15:0] first,
                                              input logic [15:0] last);
    if (last < first) return 17'd0;
    return {1'b0, last} - {1'b0, first} + 17'd1;
  endfunction

endpackage

// File: rtl/vz_hdr_rom.sv
// Combinational VZ header byte select: magic, default name, type, start address.
module vz_hdr_rom
  import vz_pkg::*;
(
  input  logic [4:0]  i_off,
  input  logic [7:0]  i_type,
  input  logic [15:0] i_start,
  output logic [7:0]  o_byte
);

  logic [4:0] w_name_idx;

  assign w_name_idx = i_off - 5'(VZ_OFF_NAME);

  always_comb begin
    // NOTE: default first so every path assigns o_byte and no latch is inferred.
    o_byte = 8'h00;
    if (i_off < 5'(VZ_OFF_NAME))
      o_byte = VZ_MAGIC[i_off[1:0]];
    else if (i_off < 5'(VZ_OFF_TYPE))
      o_byte = VZ_NAME_DEFAULT[w_name_idx];
    else if (i_off == 5'(VZ_OFF_TYPE))
      o_byte = i_type;
    else if (i_off == 5'(VZ_OFF_START))
      o_byte = i_start[7:0];
    else if (i_off == 5'(VZ_OFF_START + 1))
      o_byte = i_start[15:8];
  end

endmodule

// File: rtl/vz_upload.sv
// VZ image upload engine: serves hps_io byte reads from a generated header plus a RAM span.
// Optional running checksum of served RAM bytes when VZ_UPLOAD_CKSUM_EN is defined.
module vz_upload
  import vz_pkg::*;
#(
  parameter int HDR_LEN     = VZ_HDR_LEN,
  parameter int ACK_TIMEOUT = 255
) (
  input  logic        CLK10MHZ,
  input  logic        RESET,
  input  logic        ioctl_upload,
  input  logic        ioctl_rd,
  input  logic [15:0] ioctl_addr,
  output logic [7:0]  ioctl_din,
  output logic        busy,
  input  logic [7:0]  vz_type,
  input  logic [15:0] span_start,
  input  logic [15:0] span_end,
  output logic [16:0] file_len,
  output logic        mem_req,
  output logic [15:0] mem_addr,
  input  logic        mem_ack,
  input  logic [7:0]  mem_data
`ifdef VZ_UPLOAD_CKSUM_EN
  ,
  output logic [15:0] cksum
`endif
);

  localparam int                WAIT_W    = $clog2(ACK_TIMEOUT + 1);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(ACK_TIMEOUT - 1);

  vz_up_state_t      r_state;
  logic              r_upload_q;
  logic [7:0]        r_type;
  logic [15:0]       r_start;
  logic [16:0]       r_span_len;
  logic [4:0]        r_hdr_off;
  logic [WAIT_W-1:0] r_wait;

  logic [16:0]       w_off;
  logic              w_is_hdr;
  logic              w_in_span;
  logic [7:0]        w_hdr_byte;

  // Offset into the RAM span; only meaningful when the request is past the header.
  assign w_off     = {1'b0, ioctl_addr} - 17'(HDR_LEN);
  assign w_is_hdr  = (ioctl_addr < 16'(HDR_LEN));
  assign w_in_span = (w_off < r_span_len);

  vz_hdr_rom u_hdr_rom (
    .i_off   (r_hdr_off),
    .i_type  (r_type),
    .i_start (r_start),
    .o_byte  (w_hdr_byte)
  );

  always_ff @(posedge CLK10MHZ or negedge RESET) begin
    if (!RESET) begin
      r_state    <= IDLE;
      r_upload_q <= 1'b0;
      r_type     <= 8'h00;
      r_start    <= 16'h0000;
      r_span_len <= 17'd0;
      r_hdr_off  <= 5'd0;
      r_wait     <= '0;
      ioctl_din  <= 8'h00;
      busy       <= 1'b0;
      file_len   <= 17'd0;
      mem_req    <= 1'b0;
      mem_addr   <= 16'h0000;
    end else begin
      // NOTE: non-blocking for all state so every read in this block sees pre-edge values.
      r_upload_q <= ioctl_upload;
      if (!ioctl_upload && r_state != IDLE) begin
        // Session abort: drop any pending request, keep ioctl_din and file_len.
        r_state <= IDLE;
        mem_req <= 1'b0;
        busy    <= 1'b0;
      end else begin
        case (r_state)
          IDLE: begin
            if (ioctl_upload && !r_upload_q) r_state <= ARM;
          end
          ARM: begin
            r_type     <= vz_type;
            r_start    <= span_start;
            r_span_len <= vz_span_len(span_start, span_end);
            file_len   <= 17'(HDR_LEN) + vz_span_len(span_start, span_end);
            r_state    <= WAIT_RD;
          end
          WAIT_RD: begin
            if (ioctl_rd) begin
              busy      <= 1'b1;
              r_hdr_off <= ioctl_addr[4:0];
              if (w_is_hdr) begin
                r_state <= HDR;
              end else if (w_in_span) begin
                mem_req  <= 1'b1;
                mem_addr <= r_start + w_off[15:0];
                r_wait   <= '0;
                r_state  <= MEM;
              end else begin
                ioctl_din <= 8'h00;
                r_state   <= DONE_BYTE;
              end
            end
          end
          HDR: begin
            ioctl_din <= w_hdr_byte;
            r_state   <= DONE_BYTE;
          end
          MEM: begin
            if (mem_ack) begin
              ioctl_din <= mem_data;
              mem_req   <= 1'b0;
              r_state   <= DONE_BYTE;
            end else if (r_wait == WAIT_LAST) begin
              ioctl_din <= 8'hFF;
              mem_req   <= 1'b0;
              r_state   <= DONE_BYTE;
            end else begin
              r_wait <= r_wait + WAIT_W'(1);
            end
          end
          DONE_BYTE: begin
            busy    <= 1'b0;
            r_state <= WAIT_RD;
          end
          default: r_state <= IDLE;
        endcase
      end
    end
  end

`ifdef VZ_UPLOAD_CKSUM_EN
  logic [15:0] r_cksum;
  logic [15:0] r_off;
  logic [15:0] r_last_off;
  logic        r_last_vld;

  // Sum each acked RAM byte once; an immediate re-read of the same offset is skipped.
  always_ff @(posedge CLK10MHZ or negedge RESET) begin
    if (!RESET) begin
      r_cksum    <= 16'h0000;
      r_off      <= 16'h0000;
      r_last_off <= 16'h0000;
      r_last_vld <= 1'b0;
    end else if (ioctl_upload) begin
      if (r_state == ARM) begin
        r_cksum    <= 16'h0000;
        r_last_vld <= 1'b0;
      end
      if (r_state == WAIT_RD && ioctl_rd) r_off <= w_off[15:0];
      if (r_state == MEM && mem_ack) begin
        if (!(r_last_vld && r_last_off == r_off))
          r_cksum <= r_cksum + {8'h00, mem_data};
        r_last_off <= r_off;
        r_last_vld <= 1'b1;
      end
    end
  end

  assign cksum = r_cksum;
`endif

endmodule

// File: tb/tb_vz_upload.sv
// Scoreboard bench for vz_upload: directed reads push expected bytes, a monitor pops on busy fall.
module tb_vz_upload;
  import vz_pkg::*;

  logic        CLK10MHZ = 1'b0;
  logic        RESET;
  logic        ioctl_upload;
  logic        ioctl_rd;
  logic [15:0] ioctl_addr;
  logic [7:0]  ioctl_din;
  logic        busy;
  logic [7:0]  vz_type;
  logic [15:0] span_start;
  logic [15:0] span_end;
  logic [16:0] file_len;
  logic        mem_req;
  logic [15:0] mem_addr;
  logic        mem_ack = 1'b0;
  logic [7:0]  mem_data = 8'h00;
`ifdef VZ_UPLOAD_CKSUM_EN
  logic [15:0] cksum;
`endif

  always #5 CLK10MHZ = ~CLK10MHZ;

  vz_upload dut (
    .CLK10MHZ     (CLK10MHZ),
    .RESET        (RESET),
    .ioctl_upload (ioctl_upload),
    .ioctl_rd     (ioctl_rd),
    .ioctl_addr   (ioctl_addr),
    .ioctl_din    (ioctl_din),
    .busy         (busy),
    .vz_type      (vz_type),
    .span_start   (span_start),
    .span_end     (span_end),
    .file_len     (file_len),
    .mem_req      (mem_req),
    .mem_addr     (mem_addr),
    .mem_ack      (mem_ack),
    .mem_data     (mem_data)
`ifdef VZ_UPLOAD_CKSUM_EN
    ,
    .cksum        (cksum)
`endif
  );

  int n_checks = 0;
  int n_errors = 0;

  logic [7:0] exp_q[$];
  int         off_q[$];
  logic       mon_en = 1'b1;

  // RAM responder state: ack_delay < 0 means never ack.
  int          ack_delay = 0;
  int          req_cnt = 0;
  int          req_hi_last = 0;
  int          req_total = 0;
  logic [15:0] req_addr0 = 16'h0000;
  logic        addr_stable = 1'b1;

  // Expected image for span 0x7AE9..0x7AEB, type 0xF1.
  logic [7:0] img [27] = '{8'h56, 8'h5A, 8'h46, 8'h30,
                           8'h4C, 8'h41, 8'h53, 8'h45, 8'h52, 8'h33, 8'h31, 8'h30,
                           8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00,
                           8'hF1, 8'hE9, 8'h7A,
                           8'hFF, 8'hFF, 8'h02};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] ram_byte(input logic [15:0] a);
    case (a)
      16'h7AE9, 16'h7AEA: return 8'hFF;
      16'h7AEB:           return 8'h02;
      default:            return a[7:0] ^ 8'hA5;
    endcase
  endfunction

  initial begin
    forever begin
      @(negedge CLK10MHZ);
      mem_ack = 1'b0;
      if (mem_req) begin
        if (req_cnt == 0) begin
          req_addr0   = mem_addr;
          addr_stable = 1'b1;
        end else if (mem_addr != req_addr0) begin
          addr_stable = 1'b0;
        end
        if (ack_delay >= 0 && req_cnt == ack_delay) begin
          mem_ack  = 1'b1;
          mem_data = ram_byte(mem_addr);
        end
        req_cnt++;
        req_total++;
        req_hi_last = req_cnt;
      end else begin
        req_cnt = 0;
      end
    end
  end

  initial begin
    logic prev_busy;
    logic [7:0] e;
    int a;
    prev_busy = 1'b0;
    forever begin
      @(negedge CLK10MHZ);
      if (mon_en && prev_busy && !busy) begin
        if (exp_q.size() == 0) begin
          check("sb_underflow", 32'(exp_q.size()), 32'd1);
        end else begin
          e = exp_q.pop_front();
          a = off_q.pop_front();
          check($sformatf("din_off%0d", a), 32'(ioctl_din), 32'(e));
        end
      end
      prev_busy = busy;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic start_session(input logic [7:0] t, input logic [15:0] s, input logic [15:0] e);
    @(posedge CLK10MHZ); #1;
    ioctl_upload = 1'b0;
    @(posedge CLK10MHZ); #1;
    vz_type = t; span_start = s; span_end = e;
    ioctl_upload = 1'b1;
    @(posedge CLK10MHZ);
    @(posedge CLK10MHZ); #1;
  endtask

  task automatic rd(input logic [15:0] a, input logic [7:0] exp, output int busy_cyc);
    @(posedge CLK10MHZ); #1;
    ioctl_addr = a;
    ioctl_rd   = 1'b1;
    exp_q.push_back(exp);
    off_q.push_back(int'(a));
    @(posedge CLK10MHZ); #1;
    ioctl_rd = 1'b0;
    busy_cyc = 0;
    for (int i = 0; i < 400; i++) begin
      @(negedge CLK10MHZ);
      if (!busy) break;
      busy_cyc++;
    end
    if (busy) check("busy_release_bound", 32'(busy), 32'd0);
  endtask

  task automatic strobe(input logic [15:0] a);
    @(posedge CLK10MHZ); #1;
    ioctl_addr = a;
    ioctl_rd   = 1'b1;
    @(posedge CLK10MHZ); #1;
    ioctl_rd = 1'b0;
  endtask

  initial begin
    int bc;
    int req0;
    RESET = 1'b0; ioctl_upload = 1'b0; ioctl_rd = 1'b0; ioctl_addr = 16'h0;
    vz_type = 8'h00; span_start = 16'h0; span_end = 16'h0;
    repeat (3) @(posedge CLK10MHZ); #1;
    check("rst_din", 32'(ioctl_din), 32'h00);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_mem_req", 32'(mem_req), 32'd0);
    check("rst_mem_addr", 32'(mem_addr), 32'h0);
    check("rst_file_len", 32'(file_len), 32'd0);
    RESET = 1'b1;

    // Full image read with immediate ack; offset 25 is read twice back to back.
    ack_delay = 0;
    start_session(VZ_TYPE_BIN, 16'h7AE9, 16'h7AEB);
    check("file_len_s1", 32'(file_len), 32'd27);
    for (int i = 0; i < 27; i++) begin
      rd(16'(i), img[i], bc);
      check($sformatf("busy_cyc_off%0d", i), 32'(bc), 32'd2);
      if (i >= 24) check($sformatf("req_hi_off%0d", i), 32'(req_hi_last), 32'd1);
      if (i == 25) rd(16'd25, img[25], bc);
    end
    check("mem_addr_last", 32'(mem_addr), 32'h7AEB);
`ifdef VZ_UPLOAD_CKSUM_EN
    check("cksum_reread", 32'(cksum), 32'h0200);
`endif
    req0 = req_total;
    rd(16'd27, 8'h00, bc);
    check("oor_no_req", 32'(req_total), 32'(req0));

    // Delayed ack: request held for 10 cycles with a stable address.
    ack_delay = 9;
    rd(16'd24, 8'hFF, bc);
    check("delay_req_hi", 32'(req_hi_last), 32'd10);
    check("delay_addr_stable", 32'(addr_stable), 32'd1);
    check("delay_addr", 32'(req_addr0), 32'h7AE9);
    check("delay_busy_cyc", 32'(bc), 32'd11);

    // No ack at all: timeout after 255 request cycles serves 0xFF.
    ack_delay = -1;
    rd(16'd24, 8'hFF, bc);
    check("tmo_req_hi", 32'(req_hi_last), 32'd255);
    check("tmo_busy_cyc", 32'(bc), 32'd256);
    check("tmo_mem_req", 32'(mem_req), 32'd0);
`ifdef VZ_UPLOAD_CKSUM_EN
    check("cksum_tmo_skip", 32'(cksum), 32'h02FF);
`endif

    // Inverted span: header only.
    ack_delay = 0;
    start_session(VZ_TYPE_BASIC, 16'h8000, 16'h7000);
    check("file_len_hdr_only", 32'(file_len), 32'd24);
`ifdef VZ_UPLOAD_CKSUM_EN
    check("cksum_cleared", 32'(cksum), 32'h0000);
`endif
    req0 = req_total;
    rd(16'd24, 8'h00, bc);
    check("hdr_only_no_req", 32'(req_total), 32'(req0));
    rd(16'd21, 8'hF0, bc);
    rd(16'd22, 8'h00, bc);
    rd(16'd23, 8'h80, bc);

    // Upload dropped during a MEM wait.
    mon_en = 1'b0;
    ack_delay = -1;
    start_session(VZ_TYPE_BIN, 16'h7AE9, 16'h7AEB);
    strobe(16'd24);
    repeat (4) @(posedge CLK10MHZ); #1;
    check("drop_req_waiting", 32'(mem_req), 32'd1);
    ioctl_upload = 1'b0;
    @(posedge CLK10MHZ); #1;
    check("drop_mem_req", 32'(mem_req), 32'd0);
    check("drop_busy", 32'(busy), 32'd0);
    check("drop_din_hold", 32'(ioctl_din), 32'h80);
    check("drop_file_len_hold", 32'(file_len), 32'd27);
    strobe(16'd0);
    check("idle_rd_ignored", 32'(busy), 32'd0);
    @(posedge CLK10MHZ); #1;
    check("idle_rd_ignored2", 32'(busy), 32'd0);

    // Asynchronous reset mid-session.
    start_session(VZ_TYPE_BIN, 16'h7AE9, 16'h7AEB);
    strobe(16'd25);
    repeat (3) @(posedge CLK10MHZ); #2;
    RESET = 1'b0;
    #1;
    check("arst_din", 32'(ioctl_din), 32'h00);
    check("arst_busy", 32'(busy), 32'd0);
    check("arst_mem_req", 32'(mem_req), 32'd0);
    check("arst_mem_addr", 32'(mem_addr), 32'h0);
    check("arst_file_len", 32'(file_len), 32'd0);
    ioctl_upload = 1'b0;
    @(posedge CLK10MHZ); #1;
    RESET = 1'b1;
    strobe(16'd0);
    check("post_rst_idle", 32'(busy), 32'd0);
    repeat (2) @(posedge CLK10MHZ);
    mon_en = 1'b1;

    // Recovery: a fresh session works after reset.
    ack_delay = 0;
    start_session(VZ_TYPE_BIN, 16'h7AE9, 16'h7AEB);
    check("file_len_recover", 32'(file_len), 32'd27);
    rd(16'd0, 8'h56, bc);
    rd(16'd26, 8'h02, bc);

    repeat (3) @(posedge CLK10MHZ);
    check("sb_drained", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
